// File: rtl/timer_sched.sv
// Round-robin scheduler that shares one 16-bit one-shot timer between N_REQ requesters.
// Optional RUN-state watchdog is enabled by defining TIMER_SCHED_WDOG_EN.
module timer_sched #(
   parameter int          N_REQ       = 4,
   parameter logic [16:0] WDOG_CYCLES = 17'd70000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req,
   input  logic [16*N_REQ-1:0]  req_count,
   input  logic [N_REQ-1:0]     req_dir,
   output logic [N_REQ-1:0]     gnt,
   output logic [N_REQ-1:0]     cpl,
   output logic [N_REQ-1:0]     err,
   output logic                 busy,
   output logic                 tmr_enable,
   output logic                 tmr_set,
   output logic                 tmr_direction,
   output logic                 tmr_auto_reload,
   output logic                 tmr_done_ack,
   output logic [15:0]          tmr_count,
   input  logic                 tmr_done
);

   localparam int IW = (N_REQ > 4) ? 3 : ((N_REQ > 2) ? 2 : 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_ACK, S_CPL} state_t;

   state_t            state, state_nxt;
   logic [IW-1:0]     rr_ptr, rr_ptr_nxt;
   logic [IW-1:0]     idx, idx_nxt;
   logic [15:0]       cnt_nxt;
   logic              dir_nxt;
   logic              pick_found;
   logic [IW-1:0]     pick_idx;
   logic [15:0]       pick_count;
   logic              pick_dir;
   logic [N_REQ-1:0]  gnt_nxt, cpl_nxt;
   logic              wdog_expire;

   function automatic int wrap_add(input int a, input int b);
      int s;
      s = a + b;
      return (s >= N_REQ) ? s - N_REQ : s;
   endfunction

   assign tmr_auto_reload = 1'b0;

`ifdef TIMER_SCHED_WDOG_EN
   logic [16:0] wdog_cnt;
   logic        wdog_abort;

   // A done seen in the expiry cycle wins, so that job completes without err.
   assign wdog_expire = (state == S_RUN) && !tmr_done && (wdog_cnt == WDOG_CYCLES - 17'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_cnt   <= '0;
         wdog_abort <= 1'b0;
         err        <= '0;
      end else begin
         if (state == S_LOAD)
            wdog_cnt <= '0;
         else if (state == S_RUN)
            wdog_cnt <= wdog_cnt + 17'd1;
         if (state == S_LOAD)
            wdog_abort <= 1'b0;
         else if (wdog_expire)
            wdog_abort <= 1'b1;
         err <= wdog_abort ? cpl_nxt : '0;
      end
   end
`else
   logic unused_wdog;
   assign unused_wdog = ^WDOG_CYCLES;
   assign wdog_expire = 1'b0;
   assign err         = '0;
`endif

   // First set request at or after the RR pointer, wrapping modulo N_REQ.
   always_comb begin
      // NOTE: every variable gets a default before any branch, otherwise a latch is inferred.
      pick_found = 1'b0;
      pick_idx   = '0;
      pick_count = '0;
      pick_dir   = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!pick_found && req[wrap_add(int'(rr_ptr), k)]) begin
            pick_found = 1'b1;
            pick_idx   = IW'(wrap_add(int'(rr_ptr), k));
            pick_count = req_count[16*wrap_add(int'(rr_ptr), k) +: 16];
            pick_dir   = req_dir[wrap_add(int'(rr_ptr), k)];
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      cnt_nxt    = tmr_count;
      dir_nxt    = tmr_direction;
      rr_ptr_nxt = rr_ptr;
      case (state)
         S_IDLE: begin
            if (pick_found) begin
               state_nxt = S_LOAD;
               idx_nxt   = pick_idx;
               cnt_nxt   = pick_count;
               dir_nxt   = pick_dir;
            end
         end
         S_LOAD: state_nxt = S_RUN;
         S_RUN: begin
            if (tmr_done || wdog_expire)
               state_nxt = S_ACK;
         end
         S_ACK: state_nxt = S_CPL;
         S_CPL: begin
            state_nxt  = S_IDLE;
            rr_ptr_nxt = IW'(wrap_add(int'(idx), 1));
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_comb begin
      gnt_nxt = '0;
      cpl_nxt = '0;
      if (state_nxt == S_LOAD)
         gnt_nxt[idx_nxt] = 1'b1;
      if (state_nxt == S_CPL)
         cpl_nxt[idx_nxt] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         rr_ptr        <= '0;
         idx           <= '0;
         tmr_count     <= '0;
         tmr_direction <= 1'b0;
         gnt           <= '0;
         cpl           <= '0;
         busy          <= 1'b0;
         tmr_enable    <= 1'b0;
         tmr_set       <= 1'b0;
         tmr_done_ack  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state         <= state_nxt;
         rr_ptr        <= rr_ptr_nxt;
         idx           <= idx_nxt;
         tmr_count     <= cnt_nxt;
         tmr_direction <= dir_nxt;
         gnt           <= gnt_nxt;
         cpl           <= cpl_nxt;
         busy          <= (state_nxt != S_IDLE);
         tmr_enable    <= (state_nxt == S_LOAD) || (state_nxt == S_RUN);
         tmr_set       <= (state_nxt == S_LOAD);
         tmr_done_ack  <= (state_nxt == S_ACK);
      end
   end

endmodule
